// File: rtl/semaforo_pkg.sv
// Shared state encoding and sizing helpers for the traffic-light controller.
// Build option: SEMAFORO_PEDESTRE_EN enables the pedestrian phase.
package semaforo_pkg;

  typedef enum logic [2:0] {
    VERDE      = 3'd0,
    AMARELO    = 3'd1,
    TODOS_VERM = 3'd2,
    PEDESTRE   = 3'd3,
    PISCA      = 3'd4
  } estado_t;

  function automatic int timer_max(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

  // The counter holds "cycles remaining minus one", so T-1 must fit.
  function automatic int cnt_width(input int t_max);
    return (t_max <= 2) ? 1 : $clog2(t_max);
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/semaforo_rr.sv
// Round-robin next-approach picker: first approach with demand, scanning
// from active+1 and wrapping; active+1 when nobody is waiting.
module semaforo_rr
  import semaforo_pkg::*;
#(
  parameter int N_VIAS = 2,
  parameter int W      = idx_width(N_VIAS)
) (
  input  logic [N_VIAS-1:0] carro,
  input  logic [W-1:0]      active,
  output logic [W-1:0]      next_way
);

  logic [W-1:0] cand [N_VIAS];

  // cand[gi] is (active + gi + 1) mod N_VIAS, i.e. the scan order.
  generate
    for (genvar gi = 0; gi < N_VIAS; gi++) begin : g_cand
      logic [W:0] sum;
      assign sum      = {1'b0, active} + (W+1)'(gi + 1);
      assign cand[gi] = (sum >= (W+1)'(N_VIAS)) ? W'(sum - (W+1)'(N_VIAS)) : W'(sum);
    end
  endgenerate

  always_comb begin
    next_way = cand[0];
    for (int i = N_VIAS - 1; i >= 0; i--) begin
      if (carro[cand[i]]) next_way = cand[i];
    end
  end

endmodule

// File: rtl/semaforo_ctrl.sv
// Multi-approach traffic-light controller with night flash and optional
// pedestrian phase (enabled by defining SEMAFORO_PEDESTRE_EN).
module semaforo_ctrl
  import semaforo_pkg::*;
#(
  parameter int N_VIAS    = 2,
  parameter int T_VERDE   = 8,
  parameter int T_AMARELO = 3,
  parameter int T_TV      = 2,
  parameter int T_PISCA   = 4,
  parameter int T_PED     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_VIAS-1:0] carro,
  input  logic              noite,
  input  logic              ped_req,
  output logic [N_VIAS-1:0] verde,
  output logic [N_VIAS-1:0] amarelo,
  output logic [N_VIAS-1:0] vermelho,
  output logic              ped_verde
);

  localparam int T_MAX = timer_max(T_VERDE, T_AMARELO, T_TV, T_PISCA, T_PED);
  localparam int CNT_W = cnt_width(T_MAX);
  localparam int WAY_W = idx_width(N_VIAS);

  localparam logic [CNT_W-1:0] LD_VERDE   = CNT_W'(T_VERDE - 1);
  localparam logic [CNT_W-1:0] LD_AMARELO = CNT_W'(T_AMARELO - 1);
  localparam logic [CNT_W-1:0] LD_TV      = CNT_W'(T_TV - 1);
  localparam logic [CNT_W-1:0] LD_PISCA   = CNT_W'(T_PISCA - 1);
  localparam logic [CNT_W-1:0] LD_PED     = CNT_W'(T_PED - 1);

  estado_t           state_reg, state_next;
  logic [WAY_W-1:0]  way_reg, way_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              flash_reg, flash_next;
  logic              start_reg, start_next;
  logic [WAY_W-1:0]  rr_way;
  logic [N_VIAS-1:0] way_mask;
  logic              others;
  logic              pend;

`ifdef SEMAFORO_PEDESTRE_EN
  logic pend_reg, pend_next;
  assign pend = pend_reg;
`else
  logic ped_unused;
  assign pend       = 1'b0;
  assign ped_unused = ped_req;
`endif

  semaforo_rr #(
    .N_VIAS(N_VIAS),
    .W     (WAY_W)
  ) u_rr (
    .carro   (carro),
    .active  (way_reg),
    .next_way(rr_way)
  );

  assign way_mask = N_VIAS'(1) << way_reg;
  assign others   = |(carro & ~way_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= TODOS_VERM;
      way_reg   <= '0;
      cnt_reg   <= LD_TV;
      flash_reg <= 1'b0;
      start_reg <= 1'b1;
`ifdef SEMAFORO_PEDESTRE_EN
      pend_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      way_reg   <= way_next;
      cnt_reg   <= cnt_next;
      flash_reg <= flash_next;
      start_reg <= start_next;
`ifdef SEMAFORO_PEDESTRE_EN
      pend_reg  <= pend_next;
`endif
    end
  end

  // start_reg forces the next green onto way 0 (after reset or night flash).
  always_comb begin
    state_next = state_reg;
    way_next   = way_reg;
    cnt_next   = (cnt_reg == '0) ? '0 : cnt_reg - CNT_W'(1);
    flash_next = flash_reg;
    start_next = start_reg;
`ifdef SEMAFORO_PEDESTRE_EN
    pend_next  = pend_reg | ped_req;
`endif
    unique case (state_reg)
      VERDE: begin
        if (noite || (cnt_reg == '0 && (others || pend))) begin
          state_next = AMARELO;
          cnt_next   = LD_AMARELO;
        end
      end
      AMARELO: begin
        if (cnt_reg == '0) begin
          state_next = TODOS_VERM;
          cnt_next   = LD_TV;
        end
      end
      TODOS_VERM: begin
        if (cnt_reg == '0) begin
          if (noite) begin
            state_next = PISCA;
            cnt_next   = LD_PISCA;
            flash_next = 1'b1;
          end else if (pend) begin
            state_next = PEDESTRE;
            cnt_next   = LD_PED;
`ifdef SEMAFORO_PEDESTRE_EN
            pend_next  = ped_req;
`endif
          end else begin
            state_next = VERDE;
            cnt_next   = LD_VERDE;
            way_next   = start_reg ? '0 : rr_way;
            start_next = 1'b0;
          end
        end
      end
      PEDESTRE: begin
        if (cnt_reg == '0) begin
          state_next = TODOS_VERM;
          cnt_next   = LD_TV;
        end
      end
      PISCA: begin
        if (!noite) begin
          state_next = TODOS_VERM;
          cnt_next   = LD_TV;
          flash_next = 1'b0;
          start_next = 1'b1;
        end else if (cnt_reg == '0) begin
          flash_next = ~flash_reg;
          cnt_next   = LD_PISCA;
        end
      end
      default: begin
        state_next = TODOS_VERM;
        cnt_next   = LD_TV;
      end
    endcase
  end

  always_comb begin
    verde     = '0;
    amarelo   = '0;
    vermelho  = '1;
    ped_verde = 1'b0;
    unique case (state_reg)
      VERDE: begin
        vermelho[way_reg] = 1'b0;
        verde[way_reg]    = 1'b1;
      end
      AMARELO: begin
        vermelho[way_reg] = 1'b0;
        amarelo[way_reg]  = 1'b1;
      end
      PEDESTRE: begin
`ifdef SEMAFORO_PEDESTRE_EN
        ped_verde = 1'b1;
`endif
      end
      PISCA: begin
        vermelho = '0;
        amarelo  = {N_VIAS{flash_reg}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Bench for semaforo_ctrl: directed lamp sequences with literal expectations,
// then random traffic checked every cycle against a phase/age reference model.
module tb_semaforo_ctrl;

  localparam int N_VIAS    = 2;
  localparam int T_VERDE   = 8;
  localparam int T_AMARELO = 3;
  localparam int T_TV      = 2;
  localparam int T_PISCA   = 4;
  localparam int T_PED     = 6;

`ifdef SEMAFORO_PEDESTRE_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  localparam int PH_GREEN  = 0;
  localparam int PH_YELLOW = 1;
  localparam int PH_ALLRED = 2;
  localparam int PH_WALK   = 3;
  localparam int PH_FLASH  = 4;

  typedef struct {
    int phase;
    int way;
    int age;     // cycles spent in the current phase, starting at 1
    bit pend;
    bit first;   // next green must be way 0
    bit armed;
  } model_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_VIAS-1:0] carro = '0;
  logic              noite = 1'b0;
  logic              ped_req = 1'b0;
  logic [N_VIAS-1:0] verde, amarelo, vermelho;
  logic              ped_verde;

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  model_t m;

  semaforo_ctrl #(
    .N_VIAS(N_VIAS), .T_VERDE(T_VERDE), .T_AMARELO(T_AMARELO),
    .T_TV(T_TV), .T_PISCA(T_PISCA), .T_PED(T_PED)
  ) dut (
    .clk(clk), .rst(rst), .carro(carro), .noite(noite), .ped_req(ped_req),
    .verde(verde), .amarelo(amarelo), .vermelho(vermelho), .ped_verde(ped_verde)
  );

  always #5 clk = ~clk;

  function automatic model_t step_model(input model_t cur, input logic r,
                                        input logic [N_VIAS-1:0] c,
                                        input logic n, input logic p);
    model_t nx;
    int     nph;
    bit     others;
    bit     walk_entry;
    bit     found;
    int     pick;
    nx = cur;
    if (r) begin
      nx.phase = PH_ALLRED; nx.age = 1; nx.way = 0;
      nx.pend = 1'b0; nx.first = 1'b1; nx.armed = 1'b1;
      return nx;
    end
    if (!cur.armed) return nx;
    nph = cur.phase;
    walk_entry = 1'b0;
    others = 1'b0;
    for (int i = 0; i < N_VIAS; i++) if (i != cur.way && c[i]) others = 1'b1;
    case (cur.phase)
      PH_GREEN:  if (n || (cur.age >= T_VERDE && (others || cur.pend))) nph = PH_YELLOW;
      PH_YELLOW: if (cur.age >= T_AMARELO) nph = PH_ALLRED;
      PH_ALLRED: if (cur.age >= T_TV) begin
        if (n) nph = PH_FLASH;
        else if (cur.pend) begin
          nph = PH_WALK;
          walk_entry = 1'b1;
        end else begin
          nph = PH_GREEN;
          if (cur.first) nx.way = 0;
          else begin
            pick = (cur.way + 1) % N_VIAS;
            found = 1'b0;
            for (int k = 1; k <= N_VIAS; k++) begin
              if (!found && c[(cur.way + k) % N_VIAS]) begin
                pick = (cur.way + k) % N_VIAS;
                found = 1'b1;
              end
            end
            nx.way = pick;
          end
          nx.first = 1'b0;
        end
      end
      PH_WALK:  if (cur.age >= T_PED) nph = PH_ALLRED;
      PH_FLASH: if (!n) begin
        nph = PH_ALLRED;
        nx.first = 1'b1;
      end
      default: ;
    endcase
    if (PED_EN) nx.pend = (walk_entry ? 1'b0 : cur.pend) | p;
    nx.age = (nph == cur.phase) ? cur.age + 1 : 1;
    nx.phase = nph;
    return nx;
  endfunction

  // {ped, verde, amarelo, vermelho} implied by a model state.
  function automatic logic [3*N_VIAS:0] lamps(input model_t mm);
    logic [N_VIAS-1:0] v, a, r;
    logic p;
    v = '0; a = '0; r = '0; p = 1'b0;
    case (mm.phase)
      PH_GREEN:  begin r = '1; r[mm.way] = 1'b0; v[mm.way] = 1'b1; end
      PH_YELLOW: begin r = '1; r[mm.way] = 1'b0; a[mm.way] = 1'b1; end
      PH_ALLRED: r = '1;
      PH_WALK:   begin r = '1; p = 1'b1; end
      PH_FLASH:  if (((mm.age - 1) / T_PISCA) % 2 == 0) a = '1;
      default: ;
    endcase
    return {p, v, a, r};
  endfunction

  always @(posedge clk) begin
    m <= step_model(m, rst, carro, noite, ped_req);
    cyc <= cyc + 1;
  end

  logic [3*N_VIAS:0] exp_l, got_l;
  int lit_on;
  always @(negedge clk) begin
    if (m.armed) begin
      exp_l = lamps(m);
      got_l = {ped_verde, verde, amarelo, vermelho};
      n_vec++;
      if (got_l !== exp_l) begin
        n_err++;
        $display("FAIL model cyc %0d: lamps {p,v,a,r} got %b required %b (phase %0d age %0d way %0d)",
                 cyc, got_l, exp_l, m.phase, m.age, m.way);
      end
      if (m.phase != PH_FLASH) begin
        n_vec++;
        for (int i = 0; i < N_VIAS; i++) begin
          lit_on = int'(verde[i]) + int'(amarelo[i]) + int'(vermelho[i]);
          if (lit_on != 1) begin
            n_err++;
            $display("FAIL onehot cyc %0d way %0d: lamps lit %0d required 1", cyc, i, lit_on);
          end
        end
      end
    end
  end

  task automatic hold(input int n, input logic [N_VIAS-1:0] v, input logic [N_VIAS-1:0] a,
                      input logic [N_VIAS-1:0] r, input logic pv, input string nm);
    for (int i = 0; i < n; i++) begin
      #1;
      n_vec++;
      if ({pv, v, a, r} !== {ped_verde, verde, amarelo, vermelho}) begin
        n_err++;
        $display("FAIL %s step %0d: got v=%b a=%b r=%b p=%b required v=%b a=%b r=%b p=%b",
                 nm, i, verde, amarelo, vermelho, ped_verde, v, a, r, pv);
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; carro = '0; noite = 1'b0; ped_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // idle after reset: two all-red cycles, then way 0 green indefinitely
    do_reset();
    hold(2, 2'b00, 2'b00, 2'b11, 1'b0, "rst_allred");
    hold(20, 2'b01, 2'b00, 2'b10, 1'b0, "idle_green0");
    $display("scenario idle complete");

    // demand on way 1 from green cycle 3
    do_reset();
    hold(2, 2'b00, 2'b00, 2'b11, 1'b0, "rr_allred_a");
    hold(2, 2'b01, 2'b00, 2'b10, 1'b0, "rr_green0_early");
    carro = 2'b10;
    hold(6, 2'b01, 2'b00, 2'b10, 1'b0, "rr_green0_min");
    hold(3, 2'b00, 2'b01, 2'b10, 1'b0, "rr_yellow0");
    hold(2, 2'b00, 2'b00, 2'b11, 1'b0, "rr_allred_b");
    hold(3, 2'b10, 2'b00, 2'b01, 1'b0, "rr_green1");
    $display("scenario round_robin complete");

`ifdef SEMAFORO_PEDESTRE_EN
    // pedestrian pulse during way 0 green, no cars
    do_reset();
    hold(2, 2'b00, 2'b00, 2'b11, 1'b0, "ped_allred_a");
    hold(1, 2'b01, 2'b00, 2'b10, 1'b0, "ped_green0_a");
    ped_req = 1'b1;
    hold(1, 2'b01, 2'b00, 2'b10, 1'b0, "ped_green0_b");
    ped_req = 1'b0;
    hold(6, 2'b01, 2'b00, 2'b10, 1'b0, "ped_green0_c");
    hold(3, 2'b00, 2'b01, 2'b10, 1'b0, "ped_yellow0");
    hold(2, 2'b00, 2'b00, 2'b11, 1'b0, "ped_allred_b");
    hold(6, 2'b00, 2'b00, 2'b11, 1'b1, "ped_walk");
    hold(2, 2'b00, 2'b00, 2'b11, 1'b0, "ped_allred_c");
    hold(3, 2'b10, 2'b00, 2'b01, 1'b0, "ped_green1");
    $display("scenario pedestrian complete");
`else
    // pedestrian pulses are ignored without the pedestrian option
    do_reset();
    ped_req = 1'b1;
    hold(2, 2'b00, 2'b00, 2'b11, 1'b0, "noped_allred");
    ped_req = 1'b0;
    hold(3, 2'b01, 2'b00, 2'b10, 1'b0, "noped_green0_a");
    ped_req = 1'b1;
    hold(1, 2'b01, 2'b00, 2'b10, 1'b0, "noped_green0_b");
    ped_req = 1'b0;
    hold(16, 2'b01, 2'b00, 2'b10, 1'b0, "noped_green0_c");
    $display("scenario no_pedestrian complete");
`endif

    // night flash entered from green cycle 2
    do_reset();
    hold(2, 2'b00, 2'b00, 2'b11, 1'b0, "night_allred_a");
    hold(1, 2'b01, 2'b00, 2'b10, 1'b0, "night_green0_a");
    noite = 1'b1;
    hold(1, 2'b01, 2'b00, 2'b10, 1'b0, "night_green0_b");
    hold(3, 2'b00, 2'b01, 2'b10, 1'b0, "night_yellow0");
    hold(2, 2'b00, 2'b00, 2'b11, 1'b0, "night_allred_b");
    hold(4, 2'b00, 2'b11, 2'b00, 1'b0, "flash_on");
    hold(4, 2'b00, 2'b00, 2'b00, 1'b0, "flash_off");
    noite = 1'b0;
    hold(1, 2'b00, 2'b11, 2'b00, 1'b0, "flash_on_last");
    hold(2, 2'b00, 2'b00, 2'b11, 1'b0, "night_allred_c");
    hold(2, 2'b01, 2'b00, 2'b10, 1'b0, "night_green0_c");
    $display("scenario night complete");

    // reset during yellow
    do_reset();
    hold(2, 2'b00, 2'b00, 2'b11, 1'b0, "mid_allred_a");
    hold(1, 2'b01, 2'b00, 2'b10, 1'b0, "mid_green0_a");
    carro = 2'b10;
    hold(7, 2'b01, 2'b00, 2'b10, 1'b0, "mid_green0_b");
    hold(1, 2'b00, 2'b01, 2'b10, 1'b0, "mid_yellow0_a");
    rst = 1'b1;
    hold(1, 2'b00, 2'b01, 2'b10, 1'b0, "mid_yellow0_b");
    rst = 1'b0;
    hold(2, 2'b00, 2'b00, 2'b11, 1'b0, "mid_allred_b");
    hold(1, 2'b01, 2'b00, 2'b10, 1'b0, "mid_green0_c");
    $display("scenario reset_midphase complete");

    // random traffic, night mode and pedestrian pulses
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) carro = N_VIAS'($urandom_range(0, (1 << N_VIAS) - 1));
      if (!noite && $urandom_range(0, 149) == 0) noite = 1'b1;
      else if (noite && $urandom_range(0, 29) == 0) noite = 1'b0;
      ped_req = ($urandom_range(0, 24) == 0);
    end
    $display("scenario random complete");

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
